// File: rtl/bp_be_pkg.sv
// Shared types for the BE memory arbiter: PTW FSM state and in-flight stage tag.
// Pure type definitions; carries no timing or flow-control behaviour of its own.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_idle,
        e_issue_pend,
        e_inflight,
        e_miss_wait
    } bp_be_mem_arb_state_e;

    typedef struct packed {
        logic v;
        logic ptw;
    } bp_be_inflight_s;

endpackage

// File: rtl/bp_be_mem_arbiter_if.sv
// Issue/PTW/memory-pipe signal bundle; slave = arbiter view, master = surroundings.
// Wires only: no latency; flow control lives in the ready/valid pairs carried here.
interface bp_be_mem_arbiter_if #(
    parameter int paddr_width_p  = 56,
    parameter int dword_width_gp = 64
);
    logic                      issue_v_i;
    logic                      issue_ready_and_o;
    logic                      ptw_v_i;
    logic [paddr_width_p-1:0]  ptw_paddr_i;
    logic                      ptw_ready_and_o;
    logic                      ptw_v_o;
    logic [dword_width_gp-1:0] ptw_data_o;
    logic                      ptw_abort_o;
    logic                      mem_v_o;
    logic                      mem_ptw_o;
    logic [paddr_width_p-1:0]  mem_paddr_o;
    logic                      pipe_busy_i;
    logic                      early_v_i;
    logic [dword_width_gp-1:0] early_data_i;
    logic                      cache_replay_v_i;
    logic                      cache_miss_v_i;
    logic                      late_wb_v_i;
    logic                      late_wb_ptw_i;
    logic [dword_width_gp-1:0] late_wb_data_i;

    modport slave (
        input  issue_v_i, ptw_v_i, ptw_paddr_i, pipe_busy_i,
               early_v_i, early_data_i, cache_replay_v_i, cache_miss_v_i,
               late_wb_v_i, late_wb_ptw_i, late_wb_data_i,
        output issue_ready_and_o, ptw_ready_and_o, ptw_v_o, ptw_data_o,
               ptw_abort_o, mem_v_o, mem_ptw_o, mem_paddr_o
    );

    modport master (
        output issue_v_i, ptw_v_i, ptw_paddr_i, pipe_busy_i,
               early_v_i, early_data_i, cache_replay_v_i, cache_miss_v_i,
               late_wb_v_i, late_wb_ptw_i, late_wb_data_i,
        input  issue_ready_and_o, ptw_ready_and_o, ptw_v_o, ptw_data_o,
               ptw_abort_o, mem_v_o, mem_ptw_o, mem_paddr_o
    );

endinterface

// File: rtl/bp_be_mem_inflight_tracker.sv
// Two-stage {v, ptw} shadow of the memory pipe; flush kills issue ops, PTW ops survive.
// Stage 1 reflects the op granted two cycles earlier; no backpressure.
module bp_be_mem_inflight_tracker
    import bp_be_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            flush_i,
    input  bp_be_inflight_s stage0_i,
    output bp_be_inflight_s stage1_o
);
    bp_be_inflight_s stage0_q, stage0_d;
    bp_be_inflight_s stage1_q, stage1_d;

    always_comb begin
        stage0_d     = stage0_i;
        stage0_d.v   = stage0_i.v & (stage0_i.ptw | ~flush_i);
        stage1_d     = stage0_q;
        stage1_d.v   = stage0_q.v & (stage0_q.ptw | ~flush_i);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stage0_q <= '0;
            stage1_q <= '0;
        end else begin
            stage0_q <= stage0_d;
            stage1_q <= stage1_d;
        end
    end

    assign stage1_o = stage1_q;

endmodule

// File: rtl/bp_be_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over count).
// One-cycle update latency; never backpressures, simply holds at max_p.
module bp_be_sat_counter #(
    parameter int width_p = 3,
    parameter int max_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);
    localparam logic [width_p-1:0] max_lp = width_p'(max_p);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (up_i && (count_q != max_lp))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) count_q <= '0;
        else            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_be_mem_arbiter.sv
// Shares the memory pipe between issue and PTW; PTW results return exactly once.
// Grant is combinational (0 cycles); pipe_busy_i/flush_i block all grants, PTW held off when not idle.
module bp_be_mem_arbiter
    import bp_be_pkg::*;
#(
    parameter int paddr_width_p  = 56,
    parameter int dword_width_gp = 64,
    parameter int starve_limit_p = 4,
    parameter int cnt_width_lp   = (starve_limit_p > 0) ? $clog2(starve_limit_p + 1) : 1
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic flush_i,
    bp_be_mem_arbiter_if.slave io
);
    bp_be_mem_arb_state_e     state_q, state_d;
    logic [paddr_width_p-1:0] paddr_q, paddr_d;
    logic [cnt_width_lp-1:0]  starve_cnt;
    bp_be_inflight_s          stage0, stage1;
    logic grant_ok, ptw_elig, starved, issue_gnt, ptw_gnt, ptw_hit;

    assign ptw_hit = stage1.v & stage1.ptw;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            paddr_q <= '0;
        end else begin
            state_q <= state_d;
            paddr_q <= paddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        paddr_d = paddr_q;
        case (state_q)
            e_idle: begin
                if (io.ptw_v_i) begin
                    paddr_d = io.ptw_paddr_i;
                    state_d = e_issue_pend;
                end
            end
            e_issue_pend: begin
                if (flush_i)      state_d = e_idle;
                else if (ptw_gnt) state_d = e_inflight;
            end
            e_inflight: begin
                if (flush_i)                state_d = e_idle;
                else if (ptw_hit) begin
                    // replay outranks miss: the op never reached the miss path
                    if (io.early_v_i)             state_d = e_idle;
                    else if (io.cache_replay_v_i) state_d = e_issue_pend;
                    else if (io.cache_miss_v_i)   state_d = e_miss_wait;
                end
            end
            e_miss_wait: begin
                if (flush_i)                                state_d = e_idle;
                else if (io.late_wb_v_i && io.late_wb_ptw_i) state_d = e_idle;
            end
            default: state_d = e_idle;
        endcase
    end

    always_comb begin
        grant_ok  = ~io.pipe_busy_i & ~flush_i;
        ptw_elig  = (state_q == e_issue_pend);
        starved   = (starve_limit_p != 0) && (starve_cnt == cnt_width_lp'(starve_limit_p));
        ptw_gnt   = grant_ok & ptw_elig & ~(starved & io.issue_v_i);
        issue_gnt = grant_ok & io.issue_v_i & ~ptw_gnt;

        io.issue_ready_and_o = issue_gnt;
        io.ptw_ready_and_o   = (state_q == e_idle);
        io.mem_v_o           = issue_gnt | ptw_gnt;
        io.mem_ptw_o         = ptw_gnt;
        io.mem_paddr_o       = paddr_q;
        io.ptw_abort_o       = flush_i & (state_q != e_idle);

        io.ptw_v_o    = 1'b0;
        io.ptw_data_o = '0;
        if (!flush_i) begin
            if ((state_q == e_inflight) && ptw_hit && io.early_v_i) begin
                io.ptw_v_o    = 1'b1;
                io.ptw_data_o = io.early_data_i;
            end else if ((state_q == e_miss_wait) && io.late_wb_v_i && io.late_wb_ptw_i) begin
                io.ptw_v_o    = 1'b1;
                io.ptw_data_o = io.late_wb_data_i;
            end
        end
    end

    assign stage0.v   = issue_gnt | ptw_gnt;
    assign stage0.ptw = ptw_gnt;

    bp_be_mem_inflight_tracker u_tracker (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_i),
        .stage0_i  (stage0),
        .stage1_o  (stage1)
    );

    bp_be_sat_counter #(
        .width_p (cnt_width_lp),
        .max_p   (starve_limit_p)
    ) u_starve_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (issue_gnt | ~io.issue_v_i),
        .up_i      (io.issue_v_i & ~issue_gnt),
        .count_o   (starve_cnt)
    );

endmodule

// File: tb/tb_bp_be_mem_arbiter.sv
// Directed bench for bp_be_mem_arbiter: stimulus pushes expected grants/returns/aborts,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_bp_be_mem_arbiter;

    localparam int PW = 56;
    localparam int DW = 64;
    localparam logic [PW-1:0] ADDR_A = 56'h8000_1000;
    localparam logic [PW-1:0] ADDR_B = 56'h8000_2000;
    localparam logic [PW-1:0] ADDR_C = 56'h8000_3000;

    logic clk;
    logic rst_n;
    logic flush;

    bp_be_mem_arbiter_if #(.paddr_width_p(PW), .dword_width_gp(DW)) io();

    bp_be_mem_arbiter #(
        .paddr_width_p  (PW),
        .dword_width_gp (DW),
        .starve_limit_p (4)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .flush_i   (flush),
        .io        (io)
    );

    int total = 0;
    int bad   = 0;

    bit            gq_ptw[$];
    logic [PW-1:0] gq_addr[$];
    logic [DW-1:0] rq_data[$];
    int            exp_abort = 0;
    bit            orphan_ok = 0;

    bit m0v, m0p, m1v, m1p;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        flush               = 1'b0;
        io.issue_v_i        = 1'b0;
        io.ptw_v_i          = 1'b0;
        io.ptw_paddr_i      = '0;
        io.pipe_busy_i      = 1'b0;
        io.early_v_i        = 1'b0;
        io.early_data_i     = '0;
        io.cache_replay_v_i = 1'b0;
        io.cache_miss_v_i   = 1'b0;
        io.late_wb_v_i      = 1'b0;
        io.late_wb_ptw_i    = 1'b0;
        io.late_wb_data_i   = '0;
    endtask

    task automatic push_gnt(input bit ptw, input logic [PW-1:0] addr);
        gq_ptw.push_back(ptw);
        gq_addr.push_back(addr);
    endtask

    task automatic accept_ptw(input logic [PW-1:0] addr);
        cyc();
        io.ptw_v_i     = 1'b1;
        io.ptw_paddr_i = addr;
        #1 chk("accept_ready", io.ptw_ready_and_o, 1);
    endtask

    always @(negedge clk) begin
        total++;
        if (!io.ptw_v_o && io.ptw_data_o !== '0) begin
            bad++;
            $display("FAIL data_idle_zero: got %0h required 0", io.ptw_data_o);
        end
        total++;
        if (io.mem_v_o !== (io.issue_ready_and_o | io.mem_ptw_o)) begin
            bad++;
            $display("FAIL mem_v_form: got %0b required %0b", io.mem_v_o,
                     io.issue_ready_and_o | io.mem_ptw_o);
        end
        if (io.mem_v_o) begin
            total++;
            if (gq_ptw.size() == 0) begin
                bad++;
                $display("FAIL grant_unexpected: got mem_v ptw=%0b required none", io.mem_ptw_o);
            end else begin
                bit            ep;
                logic [PW-1:0] ea;
                ep = gq_ptw.pop_front();
                ea = gq_addr.pop_front();
                if (io.mem_ptw_o !== ep || (ep && io.mem_paddr_o !== ea)) begin
                    bad++;
                    $display("FAIL grant: got ptw=%0b addr=%0h required ptw=%0b addr=%0h",
                             io.mem_ptw_o, io.mem_paddr_o, ep, ea);
                end
            end
        end
        if (io.ptw_v_o) begin
            total++;
            if (rq_data.size() == 0) begin
                bad++;
                $display("FAIL ret_unexpected: got ptw_v data=%0h required none", io.ptw_data_o);
            end else begin
                logic [DW-1:0] ed;
                ed = rq_data.pop_front();
                if (io.ptw_data_o !== ed) begin
                    bad++;
                    $display("FAIL ret_data: got %0h required %0h", io.ptw_data_o, ed);
                end
            end
        end
        if (io.ptw_abort_o) begin
            total++;
            if (exp_abort == 0) begin
                bad++;
                $display("FAIL abort_unexpected: got 1 required 0");
            end else begin
                exp_abort--;
            end
        end
        if ((io.early_v_i || io.cache_replay_v_i || io.cache_miss_v_i) && !m1v && !orphan_ok) begin
            bad++;
            $display("FAIL orphan_result: got stage-1 result required in-flight op");
        end
        if (!rst_n) begin
            m0v = 0; m0p = 0; m1v = 0; m1p = 0;
        end else begin
            m1v = m0v & (m0p | ~flush);
            m1p = m0p;
            m0v = io.mem_v_o;
            m0p = io.mem_ptw_o;
        end
    end

    initial begin
        rst_n = 1'b0;
        clr();
        #2;
        chk("rst_ptw_ready", io.ptw_ready_and_o, 1);
        chk("rst_mem_v", io.mem_v_o, 0);
        chk("rst_ptw_v", io.ptw_v_o, 0);
        chk("rst_abort", io.ptw_abort_o, 0);
        chk("rst_issue_rdy", io.issue_ready_and_o, 0);
        #10 rst_n = 1'b1;

        // contention: PTW pending, issue waiting; PTW wins, early return 0xCF
        accept_ptw(ADDR_A);
        cyc(); io.ptw_v_i = 1'b0; io.issue_v_i = 1'b1; push_gnt(1, ADDR_A);
        #1 chk("t1_issue_held", io.issue_ready_and_o, 0);
        chk("t1_mem_ptw", io.mem_ptw_o, 1);
        cyc(); io.issue_v_i = 1'b0;
        cyc(); io.early_v_i = 1'b1; io.early_data_i = 64'hCF; rq_data.push_back(64'hCF);
        #1 chk("t1_ptw_v", io.ptw_v_o, 1);
        chk("t1_ptw_data", io.ptw_data_o, 64'hCF);
        cyc(); clr();
        #1 chk("t1_idle", io.ptw_ready_and_o, 1);

        // replay: reissue with latched address
        accept_ptw(ADDR_A);
        cyc(); io.ptw_v_i = 1'b0; push_gnt(1, ADDR_A);
        cyc();
        cyc(); io.cache_replay_v_i = 1'b1;
        #1 chk("t2_no_ret", io.ptw_v_o, 0);
        chk("t2_busy", io.ptw_ready_and_o, 0);
        cyc(); io.cache_replay_v_i = 1'b0; io.ptw_paddr_i = 56'hDEAD_0000; push_gnt(1, ADDR_A);
        #1 chk("t2_regrant_addr", io.mem_paddr_o, ADDR_A);
        cyc();
        cyc(); io.early_v_i = 1'b1; io.early_data_i = 64'h55; rq_data.push_back(64'h55);
        cyc(); clr();

        // miss: wait for late PTW writeback 7 cycles later
        accept_ptw(ADDR_B);
        cyc(); io.ptw_v_i = 1'b0; push_gnt(1, ADDR_B);
        cyc();
        cyc(); io.cache_miss_v_i = 1'b1;
        cyc(); io.cache_miss_v_i = 1'b0;
        #1 chk("t3_wait_ready", io.ptw_ready_and_o, 0);
        repeat (5) cyc();
        cyc(); io.late_wb_v_i = 1'b1; io.late_wb_ptw_i = 1'b1; io.late_wb_data_i = 64'h1234;
        rq_data.push_back(64'h1234);
        #1 chk("t3_late_ret", io.ptw_data_o, 64'h1234);
        cyc(); clr();
        #1 chk("t3_idle", io.ptw_ready_and_o, 1);

        // starvation: 4 denied cycles then issue forced through
        accept_ptw(ADDR_A);
        cyc(); io.ptw_v_i = 1'b0; io.issue_v_i = 1'b1; io.pipe_busy_i = 1'b1;
        #1 chk("t4_busy_no_gnt", io.mem_v_o, 0);
        repeat (3) cyc();
        cyc(); io.pipe_busy_i = 1'b0; push_gnt(0, '0);
        #1 chk("t4_issue_forced", io.issue_ready_and_o, 1);
        chk("t4_ptw_denied", io.mem_ptw_o, 0);
        cyc(); push_gnt(1, ADDR_A);
        #1 chk("t4_cnt_reset_ptw_wins", io.mem_ptw_o, 1);
        chk("t4_issue_denied", io.issue_ready_and_o, 0);
        cyc(); io.issue_v_i = 1'b0;
        cyc(); io.early_v_i = 1'b1; io.early_data_i = 64'h77; rq_data.push_back(64'h77);
        cyc(); clr();

        // flush in MISS_WAIT drops same-cycle late writeback
        accept_ptw(ADDR_C);
        cyc(); io.ptw_v_i = 1'b0; push_gnt(1, ADDR_C);
        cyc();
        cyc(); io.cache_miss_v_i = 1'b1;
        cyc(); io.cache_miss_v_i = 1'b0;
        cyc(); flush = 1'b1; io.late_wb_v_i = 1'b1; io.late_wb_ptw_i = 1'b1;
        io.late_wb_data_i = 64'h999; exp_abort++;
        #1 chk("t5_abort", io.ptw_abort_o, 1);
        chk("t5_dropped", io.ptw_v_o, 0);
        cyc(); clr();
        #1 chk("t5_ready", io.ptw_ready_and_o, 1);
        chk("t5_abort_once", io.ptw_abort_o, 0);

        // async reset mid-INFLIGHT
        accept_ptw(ADDR_A);
        cyc(); io.ptw_v_i = 1'b0; push_gnt(1, ADDR_A);
        cyc();
        #2 rst_n = 1'b0;
        #1 chk("t6_rst_ready", io.ptw_ready_and_o, 1);
        chk("t6_rst_mem_v", io.mem_v_o, 0);
        chk("t6_rst_ptw_v", io.ptw_v_o, 0);
        cyc(); orphan_ok = 1'b1; io.early_v_i = 1'b1; io.early_data_i = 64'hAB;
        #2 rst_n = 1'b1;
        #1 chk("t6_no_ret", io.ptw_v_o, 0);
        cyc();
        #1 chk("t6_no_ret_late", io.ptw_v_o, 0);
        cyc(); clr(); orphan_ok = 1'b0;
        #1 chk("t6_ready", io.ptw_ready_and_o, 1);

        // plain issue grant with PTW idle
        cyc(); io.issue_v_i = 1'b1; push_gnt(0, '0);
        #1 chk("t7_issue_gnt", io.issue_ready_and_o, 1);
        cyc(); clr();

        repeat (3) cyc();
        chk("end_grants_drained", 64'(gq_ptw.size()), 0);
        chk("end_rets_drained", 64'(rq_data.size()), 0);
        chk("end_aborts_drained", 64'(exp_abort), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
